// File: rtl/counter_arbiter.sv
// Round-robin owner of one shared up-counter. Each grant runs the counter for the
// owner's captured length, then pulses done (or abort if the owner lets go early).
module counter_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                     I_clk,
  input  logic                     I_rst_n,
  input  logic [NUM_REQ-1:0]       I_req,
  input  logic [NUM_REQ*WIDTH-1:0] I_len,
  output logic [NUM_REQ-1:0]       O_gnt,
  output logic [WIDTH-1:0]         O_cnt,
  output logic [NUM_REQ-1:0]       O_done,
  output logic [NUM_REQ-1:0]       O_abort,
  output logic                     O_busy
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [WIDTH-1:0]   len_q;
  logic [PtrW-1:0]    ptr_q;

  logic [PtrW-1:0]    sel;
  logic               sel_vld;
  logic [WIDTH-1:0]   sel_len;
  logic [WIDTH-1:0]   last_cnt;
  logic               at_term;
  logic               own_req;

  // Pick the first requester after the last-granted index, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      idx = (int'(ptr_q) + i) % int'(NUM_REQ);
      if (!sel_vld && I_req[idx]) begin
        sel_vld = 1'b1;
        sel     = PtrW'(idx);
      end
    end
    sel_len = I_len[sel*WIDTH +: WIDTH];
  end

  // Terminal count: a zero length behaves as length one, so the last value is 0.
  always_comb begin
    last_cnt = (len_q == '0) ? '0 : len_q - WIDTH'(1);
    at_term  = (cnt_q == last_cnt);
    own_req  = |(gnt_q & I_req);
  end

  // Abort masks done because done also requires the owner's request to be high.
  assign O_done  = gnt_q & I_req & {NUM_REQ{at_term}};
  assign O_abort = gnt_q & ~I_req;
  assign O_gnt   = gnt_q;
  assign O_cnt   = cnt_q;
  assign O_busy  = |gnt_q;

  // Grant FSM: arbitrate in idle, count the captured length in run.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ptr_q   <= PtrW'(NUM_REQ - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_vld) begin
            gnt_q   <= NUM_REQ'(1) << sel;
            cnt_q   <= '0;
            len_q   <= sel_len;
            ptr_q   <= sel;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (!own_req || at_term) begin
            gnt_q   <= '0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
        end
        default: begin
          gnt_q   <= '0;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model (owner, cycles left, captured length).
module tb_counter_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int VW      = 3 * NUM_REQ + WIDTH + 1;

  logic                     I_clk = 1'b0;
  logic                     I_rst_n;
  logic [NUM_REQ-1:0]       I_req;
  logic [NUM_REQ*WIDTH-1:0] I_len;
  logic [NUM_REQ-1:0]       O_gnt;
  logic [WIDTH-1:0]         O_cnt;
  logic [NUM_REQ-1:0]       O_done;
  logic [NUM_REQ-1:0]       O_abort;
  logic                     O_busy;

  int errors = 0;
  int checks = 0;

  counter_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .I_clk  (I_clk),
    .I_rst_n(I_rst_n),
    .I_req  (I_req),
    .I_len  (I_len),
    .O_gnt  (O_gnt),
    .O_cnt  (O_cnt),
    .O_done (O_done),
    .O_abort(O_abort),
    .O_busy (O_busy)
  );

  always #5 I_clk = ~I_clk;

  // Reference model: who owns the counter, how many grant cycles remain.
  int                 m_owner;
  int                 m_left;
  int                 m_len_eff;
  int                 m_ptr;
  logic [NUM_REQ-1:0] exp_gnt, exp_done, exp_abort;
  logic [WIDTH-1:0]   exp_cnt;
  logic               exp_busy;
  logic [VW-1:0]      exp_vec;

  function automatic logic [VW-1:0] obs_vec();
    return {O_gnt, O_cnt, O_done, O_abort, O_busy};
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_left    = 0;
    m_len_eff = 0;
    m_ptr     = NUM_REQ - 1;
  endtask

  // Expected outputs for the current cycle from model state and live inputs.
  task automatic model_eval();
    exp_gnt   = '0;
    exp_cnt   = '0;
    exp_done  = '0;
    exp_abort = '0;
    exp_busy  = 1'b0;
    if (m_owner >= 0) begin
      exp_gnt[m_owner] = 1'b1;
      exp_cnt          = WIDTH'(m_len_eff - m_left);
      exp_busy         = 1'b1;
      if (!I_req[m_owner]) exp_abort[m_owner] = 1'b1;
      else if (m_left == 1) exp_done[m_owner] = 1'b1;
    end
    exp_vec = {exp_gnt, exp_cnt, exp_done, exp_abort, exp_busy};
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_step();
    if (m_owner < 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int i = (m_ptr + k) % NUM_REQ;
        if (m_owner < 0 && I_req[i]) begin
          m_owner   = i;
          m_len_eff = int'(I_len[i*WIDTH +: WIDTH]);
          if (m_len_eff == 0) m_len_eff = 1;
          m_left = m_len_eff;
          m_ptr  = i;
        end
      end
    end else if (!I_req[m_owner] || m_left == 1) begin
      m_owner = -1;
    end else begin
      m_left--;
    end
  endtask

  task automatic do_reset();
    I_rst_n = 1'b0;
    I_req   = '0;
    I_len   = '0;
    @(negedge I_clk);
    I_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    I_rst_n = 1'b0;
    I_req   = 4'b1010;
    I_len   = {4{8'd3}};
    @(negedge I_clk);
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=0", obs_vec());
    end
    @(negedge I_clk);
    I_rst_n = 1'b1;
    I_req   = '0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
      model_step();
      @(negedge I_clk);
    end
  endtask

  task automatic test_single();
    int gnt_cycles = 0;
    int done_cnt   = 0;
    logic drop;
    do_reset();
    I_len[0 +: WIDTH] = 8'd5;
    I_req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL single cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
      if (O_gnt == 4'b0001) gnt_cycles++;
      if (O_done[0]) done_cnt++;
      drop = exp_done[0];
      model_step();
      @(negedge I_clk);
      if (drop) I_req[0] = 1'b0;
    end
    checks++;
    if (gnt_cycles != 5) begin
      errors++;
      $display("FAIL single_len got=%0d exp=5", gnt_cycles);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL single_done got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int done_cnt[NUM_REQ] = '{0, 0, 0, 0};
    int exp_dc[NUM_REQ]   = '{2, 1, 1, 1};
    logic [NUM_REQ-1:0] prev = '0;
    do_reset();
    I_len = {4{8'd2}};
    I_req = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL rr cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (O_gnt[i] && prev == '0) order.push_back(i);
        if (O_done[i]) done_cnt[i]++;
      end
      prev = O_gnt;
      model_step();
      @(negedge I_clk);
    end
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (n >= order.size() || order[n] != exp_order[n]) begin
        errors++;
        $display("FAIL rr_order idx=%0d got=%0d exp=%0d", n,
                 (n < order.size()) ? order[n] : -1, exp_order[n]);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (done_cnt[i] != exp_dc[i]) begin
        errors++;
        $display("FAIL rr_done req=%0d got=%0d exp=%0d", i, done_cnt[i], exp_dc[i]);
      end
    end
  endtask

  task automatic test_abort();
    int abort_c = -10;
    do_reset();
    I_len[2*WIDTH +: WIDTH] = 8'd10;
    I_req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      if (m_owner == 2 && (m_len_eff - m_left) == 3) begin
        I_req[2] = 1'b0;
        abort_c  = c;
      end
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL abort cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
      if (c == abort_c) begin
        checks++;
        if (O_abort !== 4'b0100 || O_done !== 4'b0000) begin
          errors++;
          $display("FAIL abort_pulse abort=%b done=%b exp abort=0100 done=0000",
                   O_abort, O_done);
        end
      end
      if (c == abort_c + 1) begin
        checks++;
        if (O_gnt !== 4'b0000 || O_cnt !== 8'd0) begin
          errors++;
          $display("FAIL abort_after gnt=%b cnt=%0d exp gnt=0000 cnt=0", O_gnt, O_cnt);
        end
      end
      model_step();
      @(negedge I_clk);
    end
    checks++;
    if (abort_c != 4) begin
      errors++;
      $display("FAIL abort_cycle got=%0d exp=4", abort_c);
    end
  endtask

  task automatic test_len_edges();
    int gnt_cycles = 0;
    int max_cnt    = 0;
    int done_at    = -1;
    logic [NUM_REQ-1:0] drop;
    do_reset();
    I_len[0 +: WIDTH] = 8'd0;
    I_req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL len0 cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
      if (c == 1) begin
        checks++;
        if ({O_gnt, O_cnt, O_done} !== {4'b0001, 8'd0, 4'b0001}) begin
          errors++;
          $display("FAIL len0_done gnt=%b cnt=%0d done=%b exp 0001/0/0001",
                   O_gnt, O_cnt, O_done);
        end
      end
      drop = exp_done;
      model_step();
      @(negedge I_clk);
      I_req = I_req & ~drop;
    end
    I_len[1*WIDTH +: WIDTH] = 8'd255;
    I_req = 4'b0010;
    for (int c = 0; c < 260; c++) begin
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL len255 cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
      if (O_gnt[1]) gnt_cycles++;
      if (int'(O_cnt) > max_cnt) max_cnt = int'(O_cnt);
      if (O_done[1]) done_at = int'(O_cnt);
      drop = exp_done;
      model_step();
      @(negedge I_clk);
      I_req = I_req & ~drop;
    end
    checks++;
    if (gnt_cycles != 255 || max_cnt != 254 || done_at != 254) begin
      errors++;
      $display("FAIL len255_sum cycles=%0d max=%0d done_at=%0d exp 255/254/254",
               gnt_cycles, max_cnt, done_at);
    end
  endtask

  task automatic test_len_capture();
    int gnt_cycles = 0;
    logic [NUM_REQ-1:0] drop;
    do_reset();
    I_len[3*WIDTH +: WIDTH] = 8'd6;
    I_req = 4'b1000;
    for (int c = 0; c < 9; c++) begin
      if (c == 3) I_len[3*WIDTH +: WIDTH] = 8'd2;
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL capture cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
      if (O_gnt[3]) gnt_cycles++;
      drop = exp_done;
      model_step();
      @(negedge I_clk);
      I_req = I_req & ~drop;
    end
    checks++;
    if (gnt_cycles != 6) begin
      errors++;
      $display("FAIL capture_len got=%0d exp=6", gnt_cycles);
    end
  endtask

  task automatic test_reset_mid();
    logic hit = 1'b0;
    do_reset();
    I_len[1*WIDTH +: WIDTH] = 8'd8;
    I_req = 4'b0010;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (m_owner == 1 && (m_len_eff - m_left) == 3) begin
        hit = 1'b1;
        #2;
        I_rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
          errors++;
          $display("FAIL reset_mid got=%h exp=0", obs_vec());
        end
        model_reset();
        @(negedge I_clk);
        I_rst_n = 1'b1;
        I_req   = 4'b0011;
        I_len[0 +: WIDTH] = 8'd3;
      end else begin
        #1;
        model_eval();
        checks++;
        if (obs_vec() !== exp_vec) begin
          errors++;
          $display("FAIL reset_pre cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
        end
        model_step();
        @(negedge I_clk);
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach got=0 exp=1");
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL reset_post cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
      if (c == 1) begin
        checks++;
        if (O_gnt !== 4'b0001) begin
          errors++;
          $display("FAIL reset_ptr gnt=%b exp=0001", O_gnt);
        end
      end
      model_step();
      @(negedge I_clk);
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] drop = '0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (drop[i]) begin
          I_req[i] = 1'b0;
        end else if (!I_req[i] && $urandom_range(3) == 0) begin
          I_len[i*WIDTH +: WIDTH] = ($urandom_range(9) == 0) ? WIDTH'($urandom_range(40))
                                                              : WIDTH'($urandom_range(6));
          I_req[i] = 1'b1;
        end else if (I_req[i] && m_owner == i && $urandom_range(24) == 0) begin
          I_req[i] = 1'b0;
        end
        if ($urandom_range(7) == 0) I_len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(12));
      end
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d req=%b got=%h exp=%h", c, I_req, obs_vec(), exp_vec);
      end
      checks++;
      if (!$onehot0(O_gnt) || (O_done & O_abort) != '0) begin
        errors++;
        $display("FAIL random_inv cyc=%0d gnt=%b done=%b abort=%b", c, O_gnt, O_done, O_abort);
      end
      drop = exp_done;
      model_step();
      @(negedge I_clk);
    end
  endtask

  initial begin
    I_rst_n = 1'b0;
    I_req   = '0;
    I_len   = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_len_edges();
    test_len_capture();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Round-robin scheduler that shares one WIDTH-bit up-counter between NUM_REQ requesters.
- Each requester asks for exclusive use of the counter for a programmed number of cycles.
- The block grants requesters one at a time, runs the shared counter for the granted length, then pulses done to the owner.
- Sits between the timing clients and the counter datapath, replacing free-running per-client counters.

Parameters:
WIDTH, 8, counter and length width in bits
NUM_REQ, 4, number of requesters (2..8)

Ports:
I_clk  input  1  system clock, rising edge
I_rst_n  input  1  asynchronous active-low reset
I_req  input  NUM_REQ  per-requester level request; held high until done or abort
I_len  input  NUM_REQ*WIDTH  per-requester run length; slice i = I_len[i*WIDTH +: WIDTH]
O_gnt  output  NUM_REQ  one-hot grant, registered
O_cnt  output  WIDTH  shared counter value during grant, registered
O_done  output  NUM_REQ  one-cycle pulse on the owner's last grant cycle
O_abort  output  NUM_REQ  one-cycle pulse when the owner drops its request early
O_busy  output  1  equals |O_gnt

Behaviour:
- Reset (I_rst_n low, asynchronous): O_gnt=0, O_cnt=0, O_done=0, O_abort=0, O_busy=0, FSM=IDLE, last-grant pointer ptr=NUM_REQ-1 (requester 0 has first priority).
- FSM has two states, IDLE and RUN.
- IDLE:
  - If I_req==0, stay in IDLE with all outputs 0.
  - Otherwise select the first requesting index scanning ptr+1, ptr+2, ... mod NUM_REQ.
  - On the next edge: O_gnt = onehot(sel), O_cnt = 0, len_q = I_len slice sel, ptr = sel, state -> RUN.
  - len_q is captured once; later changes to I_len do not affect the active grant.
  - Length rule: len_q==0 is treated as 1.
- RUN, owner index g:
  - Normal count: if I_req[g]==1 and O_cnt != L-1, then O_cnt <= O_cnt+1.
  - Terminal: O_done[g] is combinationally high while O_gnt[g]==1 and O_cnt==L-1 and I_req[g]==1. On that edge O_gnt -> 0, O_cnt -> 0, state -> IDLE.
  - Abort: if I_req[g]==0 in any RUN cycle, O_abort[g] is high that cycle (combinational) and O_done stays 0. On that edge O_gnt -> 0, O_cnt -> 0, state -> IDLE.
  - Requests from other indices are ignored during RUN; they wait, no loss.
- Timing: a request seen in IDLE at cycle k gives O_gnt high for cycles k+1 .. k+L, with O_done in cycle k+L.
  - Re-arbitration takes one IDLE cycle, so there is a 1-cycle gap of O_gnt=0 between consecutive grants.
  - Back-to-back throughput is therefore L+1 cycles per grant.
- Simultaneous events:
  - Abort and terminal in the same cycle: abort wins, no done.
  - The owner re-raising its request after done is eligible next IDLE, but round-robin places it after the other pending requesters.
- Maximum length: L = 2^WIDTH-1. The counter never wraps: O_cnt <= L-1 always.
- Invariants: O_gnt is one-hot or zero; O_done and O_abort are never both high; both are zero whenever O_gnt is zero.
- Reset asserted mid-RUN clears everything immediately. No done or abort is issued for the lost grant.

Test Plan:
- Single request: reset, then I_req=4'b0001, len0=5 -> O_gnt=0001 for 5 cycles, O_cnt 0,1,2,3,4, O_done[0] in the O_cnt=4 cycle, then O_gnt=0.
- Round-robin: I_req=4'b1111 held, all len=2 -> grant order 0,1,2,3,0; each grant 2 cycles; 1 idle cycle between grants; O_done[i] once per grant.
- Abort: req2 granted with len=10, I_req[2] dropped when O_cnt=3 -> O_abort[2] that cycle, O_done=0, O_gnt=0 next cycle, O_cnt=0.
- Length edge cases:
  - len=0 -> 1-cycle grant with O_cnt=0 and O_done the same cycle.
  - len=255 -> O_cnt reaches 254, no wrap, done at 254.
- Length capture: change I_len slice mid-grant from 6 to 2 -> the grant still lasts 6 cycles.
- Reset mid-op: req1 granted with len=8, I_rst_n pulsed low at O_cnt=3 (not on a clock edge) -> all outputs 0 immediately. After release with req0 and req1 pending, req0 is granted first (ptr reset).
